axi_poll_reader: RTL

AXI_POLL_READER -- requirements
Module: axi_poll_reader

---
 rtl/ariane_axi_pkg.sv | 84 ++++++++
 rtl/axi_poll_pkg.sv | 38 +++
 rtl/axi_poll_reader_timer.sv | 41 ++++
 rtl/axi_poll_reader.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ariane_axi_pkg.sv
// ============================================================================
//  Module      : ariane_axi (package)
//  Description : AXI4 channel and request/response bundle types with the
//                ariane_axi field layout (4-bit ID, 64-bit address/data).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ariane_axi;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic        user;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic        user;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

`default_nettype wire

// File: rtl/axi_poll_pkg.sv
// ============================================================================
//  Module      : axi_poll_pkg
//  Description : Shared FSM state type, AXI encodings and default parameter
//                values for the periodic AXI poll reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_poll_pkg;

  typedef enum logic [2:0] {
    START_WAIT  = 3'd0,
    PERIOD_WAIT = 3'd1,
    ADDR        = 3'd2,
    DATA        = 3'd3,
    DONE        = 3'd4
  } state_e;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [2:0] AXI_SIZE_8B     = 3'd3;
  localparam logic [3:0] AXI_AR_ID       = 4'd1;

  localparam int          DEF_ADDR_W      = 64;
  localparam int          DEF_DATA_W      = 64;
  localparam logic [63:0] DEF_BASE_ADDR   = 64'hBC00_0000;
  localparam int          DEF_NUM_ADDR    = 4;
  localparam logic [63:0] DEF_STRIDE      = 64'h8;
  localparam int          DEF_BURST_LEN   = 1;
  localparam int          DEF_START_DELAY = 250_000_000;
  localparam int          DEF_PERIOD      = 5_000_000;
  localparam int          DEF_TIMEOUT     = 1024;
  localparam int          TIMER_W         = 32;

endpackage

`default_nettype wire

// File: rtl/axi_poll_reader_timer.sv
// ============================================================================
//  Module      : poll_timer
//  Description : Loadable up-counter; tc_o pulses when the count equals
//                limit_i while enabled, and the counter then restarts at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module poll_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == limit_i);

  // Next count: load wins, terminal count wraps to zero, otherwise count up
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = load_val_i;
    else if (tc_o) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/axi_poll_reader.sv
// ============================================================================
//  Module      : axi_poll_reader
//  Description : Periodically issues AXI read bursts over a table of
//                addresses, publishing the first beat of each burst.
//                Optional watchdog enabled by defining AXI_POLL_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_poll_reader
  import axi_poll_pkg::*;
#(
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          DATA_W      = DEF_DATA_W,
  parameter logic [63:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          NUM_ADDR    = DEF_NUM_ADDR,
  parameter logic [63:0] STRIDE      = DEF_STRIDE,
  parameter int          BURST_LEN   = DEF_BURST_LEN,
  parameter int          START_DELAY = DEF_START_DELAY,
  parameter int          PERIOD      = DEF_PERIOD,
  parameter int          TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output ariane_axi::req_t  axi_req_o,
  input  ariane_axi::resp_t axi_resp_i,
  output logic [DATA_W-1:0] data_o,
  output logic [7:0]        leds_o,
  output logic              data_valid_o,
  output logic [7:0]        addr_idx_o,
  output logic [15:0]       err_cnt_o,
  output logic              busy_o,
  output logic              timeout_o
);

  state_e              state_q, state_d;
  logic                w_ar_valid, w_r_ready, w_busy;
  logic                w_tc, w_tmr_load, w_tmr_en;
  logic [TIMER_W-1:0]  w_tmr_limit;
  logic                w_ar_hs, w_r_hs;
  logic [63:0]         w_ar_addr;

  logic [DATA_W-1:0]   beat_q, data_q;
  logic [7:0]          leds_q, idx_q;
  logic [15:0]         err_cnt_q;
  logic                first_q, burst_err_q, dv_q;

  assign w_ar_hs   = w_ar_valid && axi_resp_i.ar_ready;
  assign w_r_hs    = w_r_ready && axi_resp_i.r_valid;
  assign w_ar_addr = BASE_ADDR + 64'(idx_q) * STRIDE;

  // Start-up delay and inter-poll period share one timer; it is parked at 0
  // while a transaction is in flight so PERIOD_WAIT always starts fresh.
  assign w_tmr_load  = !((state_q == START_WAIT) || (state_q == PERIOD_WAIT));
  assign w_tmr_en    = (state_q == START_WAIT) || ((state_q == PERIOD_WAIT) && en_i);
  assign w_tmr_limit = (state_q == START_WAIT) ? TIMER_W'(START_DELAY - 1)
                                               : TIMER_W'(PERIOD - 1);

  poll_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_tmr_load),
    .load_val_i ('0),
    .en_i       (w_tmr_en),
    .limit_i    (w_tmr_limit),
    .tc_o       (w_tc)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= START_WAIT;
    else       state_q <= state_d;
  end

  // FSM next-state logic; en_i only gates PERIOD_WAIT so bursts never abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      START_WAIT:  if (w_tc) state_d = PERIOD_WAIT;
      PERIOD_WAIT: if (w_tc) state_d = ADDR;
      ADDR:        if (axi_resp_i.ar_ready) state_d = DATA;
      DATA:        if (axi_resp_i.r_valid && axi_resp_i.r.last) state_d = DONE;
      DONE:        state_d = PERIOD_WAIT;
      default:     state_d = START_WAIT;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    w_ar_valid = (state_q == ADDR);
    w_r_ready  = (state_q == DATA);
    w_busy     = (state_q == ADDR) || (state_q == DATA) || (state_q == DONE);
  end

  // AXI request: read address channel only, write channels held idle
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.ar.id    = AXI_AR_ID;
    axi_req_o.ar.addr  = w_ar_addr;
    axi_req_o.ar.len   = 8'(BURST_LEN - 1);
    axi_req_o.ar.size  = AXI_SIZE_8B;
    axi_req_o.ar.burst = AXI_BURST_INCR;
    axi_req_o.ar_valid = w_ar_valid;
    axi_req_o.r_ready  = w_r_ready;
  end

  // Burst capture and result publication
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q      <= '0;
      data_q      <= '0;
      leds_q      <= '0;
      idx_q       <= '0;
      err_cnt_q   <= '0;
      first_q     <= 1'b0;
      burst_err_q <= 1'b0;
      dv_q        <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (state_q == ADDR) begin
        first_q     <= 1'b1;
        burst_err_q <= 1'b0;
      end
      if ((state_q == DATA) && w_r_hs) begin
        if (first_q) begin
          beat_q  <= axi_resp_i.r.data[DATA_W-1:0];
          first_q <= 1'b0;
        end
        if (axi_resp_i.r.resp[1]) burst_err_q <= 1'b1;
      end
      if (state_q == DONE) begin
        data_q <= beat_q;
        leds_q <= beat_q[7:0];
        dv_q   <= 1'b1;
        if (burst_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
        idx_q  <= (idx_q == 8'(NUM_ADDR - 1)) ? 8'd0 : idx_q + 8'd1;
      end
    end
  end

`ifdef AXI_POLL_WATCHDOG_EN
  logic [TIMER_W-1:0] wd_q;
  logic               timeout_q;
  logic               w_wd_run;

  assign w_wd_run = (state_q == ADDR) || (state_q == DATA);

  // Watchdog: counts stalled cycles in ADDR/DATA, any handshake restarts it;
  // it only observes the bus, so handshakes proceed regardless of the flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (!w_wd_run || w_ar_hs || w_r_hs) begin
      wd_q <= '0;
    end else if (wd_q != TIMER_W'(TIMEOUT)) begin
      wd_q <= wd_q + 1'b1;
      if (wd_q == TIMER_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  logic w_unused_resp;
  assign w_unused_resp = ^{axi_resp_i.aw_ready, axi_resp_i.w_ready, axi_resp_i.b_valid,
                           axi_resp_i.b, axi_resp_i.r.id, axi_resp_i.r.resp[0],
                           axi_resp_i.r.user, axi_resp_i.r.data, w_ar_hs};

  assign data_o       = data_q;
  assign leds_o       = leds_q;
  assign data_valid_o = dv_q;
  assign addr_idx_o   = idx_q;
  assign err_cnt_o    = err_cnt_q;
  assign busy_o       = w_busy;

endmodule

`default_nettype wire
